ema_calculator: RTL and testbench

Downstream consumer of the packet snooper's per-packet size output. It computes a fixed-point exponential moving average (EMA) of packet sizes during a measurement window. When the window closes, it reports the EMA and the sample count as a multi-beat AXI-Stream message. It sits between the snooper's `packet_size`/`packet_size_valid`/`measure_sync_out` outputs and the host-facing statistics stream.

---
 rtl/ema_calculator.sv | 163 ++++++++++++++++
 tb/tb_ema_calculator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ema_calculator.sv
// rtl/ema_calculator.sv - fixed-point EMA of packet sizes over a measurement window, reported on a stream
//
// Parameters:
//   ALPHA_SHIFT  smoothing factor alpha = 2^-ALPHA_SHIFT (1..16)
//   FRAC_BITS    fractional bits of the EMA fixed-point format (0..16)
// Optional feature macro:
//   EMA_PEAK_EN  adds a peak-size register and a third report beat
// Ports:
//   clk, aresetn                     clock, synchronous active-low reset
//   packet_size, packet_size_valid   per-packet byte count from the snooper
//   measure_in                       measurement window (snooper measure_sync_out)
//   ema_stream_T*                    report stream: beat 0 ema, beat 1 count, [beat 2 peak]
module ema_calculator #(
    parameter int ALPHA_SHIFT = 3,
    parameter int FRAC_BITS   = 8
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic [63:0] packet_size,
    input  logic        packet_size_valid,
    input  logic        measure_in,
    output logic [63:0] ema_stream_TDATA,
    output logic [7:0]  ema_stream_TKEEP,
    output logic        ema_stream_TVALID,
    input  logic        ema_stream_TREADY,
    output logic        ema_stream_TLAST
);

    typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

`ifdef EMA_PEAK_EN
    localparam logic [1:0] LAST_BEAT = 2'd2;
`else
    localparam logic [1:0] LAST_BEAT = 2'd1;
`endif

    state_t      state;
    logic [63:0] ema;
    logic [63:0] count;
    logic [1:0]  beat;

    logic               accept;
    logic [63:0]        sample_fx;
    logic signed [64:0] diff;
    logic [63:0]        step;
    logic [63:0]        ema_next;
    logic [63:0]        count_next;
    logic [1:0]         beat_nxt;
    logic [63:0]        beat_nxt_data;

    assign accept = packet_size_valid && (state == MEASURE);

    // Shifting left drops the top FRAC_BITS bits, which is exactly the
    // {packet_size[63-FRAC_BITS:0], zeros} placement, and stays legal at FRAC_BITS=0.
    assign sample_fx = packet_size << FRAC_BITS;

    // 65-bit signed difference; the arithmetic shift floors toward -inf.
    // The updated ema lies between ema and sample_fx, so a modulo-2^64 add
    // of the truncated step is exact.
    assign diff = $signed({1'b0, sample_fx}) - $signed({1'b0, ema});
    assign step = 64'(diff >>> ALPHA_SHIFT);

    always_comb begin
        ema_next   = ema;
        count_next = count;
        if (accept) begin
            ema_next = (count == 64'd0) ? sample_fx : ema + step;
            if (count != {64{1'b1}}) begin
                count_next = count + 64'd1;
            end
        end
    end

`ifdef EMA_PEAK_EN
    logic [63:0] peak;
    logic [63:0] peak_next;

    always_comb begin
        peak_next = peak;
        if (accept && (packet_size > peak)) begin
            peak_next = packet_size;
        end
    end
`endif

    assign beat_nxt = beat + 2'd1;

    always_comb begin
        beat_nxt_data = 64'd0;
        case (beat_nxt)
            2'd1:    beat_nxt_data = count;
`ifdef EMA_PEAK_EN
            2'd2:    beat_nxt_data = peak;
`endif
            default: beat_nxt_data = 64'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state             <= IDLE;
            ema               <= 64'd0;
            count             <= 64'd0;
            beat              <= 2'd0;
            ema_stream_TDATA  <= 64'd0;
            ema_stream_TKEEP  <= 8'd0;
            ema_stream_TVALID <= 1'b0;
            ema_stream_TLAST  <= 1'b0;
`ifdef EMA_PEAK_EN
            peak              <= 64'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ema   <= 64'd0;
                    count <= 64'd0;
                    beat  <= 2'd0;
`ifdef EMA_PEAK_EN
                    peak  <= 64'd0;
`endif
                    if (measure_in) begin
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    ema   <= ema_next;
                    count <= count_next;
`ifdef EMA_PEAK_EN
                    peak  <= peak_next;
`endif
                    // A sample arriving as the window closes is folded into beat 0.
                    if (!measure_in) begin
                        state             <= REPORT;
                        beat              <= 2'd0;
                        ema_stream_TDATA  <= ema_next;
                        ema_stream_TKEEP  <= 8'hFF;
                        ema_stream_TVALID <= 1'b1;
                        ema_stream_TLAST  <= 1'b0;
                    end
                end
                REPORT: begin
                    if (ema_stream_TVALID && ema_stream_TREADY) begin
                        if (beat == LAST_BEAT) begin
                            state             <= IDLE;
                            ema_stream_TDATA  <= 64'd0;
                            ema_stream_TKEEP  <= 8'd0;
                            ema_stream_TVALID <= 1'b0;
                            ema_stream_TLAST  <= 1'b0;
                        end else begin
                            beat             <= beat_nxt;
                            ema_stream_TDATA <= beat_nxt_data;
                            ema_stream_TLAST <= (beat_nxt == LAST_BEAT);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ema_calculator.sv
// tb/tb_ema_calculator.sv - randomized self-checking bench for ema_calculator
module tb_ema_calculator;

    localparam int ALPHA = 3;
    localparam int FRAC  = 8;
`ifdef EMA_PEAK_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [63:0] packet_size = 64'd0;
    logic        packet_size_valid = 1'b0;
    logic        measure_in = 1'b0;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        tlast;

    int checks = 0;
    int errors = 0;

    logic [63:0] samp_q[$];
    logic [63:0] exp_beats[3];

    always #5 clk = ~clk;

    ema_calculator #(.ALPHA_SHIFT(ALPHA), .FRAC_BITS(FRAC)) dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .packet_size       (packet_size),
        .packet_size_valid (packet_size_valid),
        .measure_in        (measure_in),
        .ema_stream_TDATA  (tdata),
        .ema_stream_TKEEP  (tkeep),
        .ema_stream_TVALID (tvalid),
        .ema_stream_TREADY (tready),
        .ema_stream_TLAST  (tlast)
    );

    // Reference: EMA with floor division by 2^ALPHA, in plain integer arithmetic.
    task automatic model();
        longint e = 0;
        longint d;
        longint q;
        longint s;
        longint pk = 0;
        foreach (samp_q[i]) begin
            s = longint'(samp_q[i]) * (64'sd1 << FRAC);
            if (i == 0) begin
                e = s;
            end else begin
                d = s - e;
                if (d >= 0) q = d / (64'sd1 << ALPHA);
                else        q = -((-d + (64'sd1 << ALPHA) - 1) / (64'sd1 << ALPHA));
                e = e + q;
            end
            if (longint'(samp_q[i]) > pk) pk = longint'(samp_q[i]);
        end
        exp_beats[0] = 64'(e);
        exp_beats[1] = 64'(samp_q.size());
        exp_beats[2] = 64'(pk);
    endtask

    // Drives one window from IDLE; returns at the negedge after the REPORT entry edge.
    task automatic drive_window(input bit boundary);
        int n = samp_q.size();
        measure_in = 1'b1;
        @(negedge clk);
        if (n == 0) begin
            repeat (10) @(negedge clk);
        end
        for (int i = 0; i < n; i++) begin
            if (!(boundary && i == n - 1)) begin
                packet_size = samp_q[i];
                packet_size_valid = 1'b1;
                @(negedge clk);
                packet_size_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        measure_in = 1'b0;
        if (boundary && n > 0) begin
            packet_size = samp_q[n - 1];
            packet_size_valid = 1'b1;
        end
        @(negedge clk);
        packet_size_valid = 1'b0;
        packet_size = 64'($urandom);
    endtask

    task automatic collect(input int stall, input bit pulse, input string tag);
        int got = 0;
        int cyc = 0;
        logic [63:0] prev = 64'd0;
        bit prev_stall = 1'b0;
        model();
        checks++;
        if (tvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s entry_tvalid got %b want 1", tag, tvalid);
        end
        while (got < NB && cyc < 300) begin
            tready = (cyc >= stall) ? 1'b1 : 1'b0;
            measure_in = pulse && (cyc < 4);
            if (prev_stall) begin
                checks++;
                if (tvalid !== 1'b1 || tdata !== prev) begin
                    errors++;
                    $display("FAIL %s hold got v=%b d=%0d want v=1 d=%0d", tag, tvalid, tdata, prev);
                end
            end
            if (tvalid === 1'b1 && tready) begin
                checks++;
                if (tdata !== exp_beats[got] || tlast !== (got == NB - 1) || tkeep !== 8'hFF) begin
                    errors++;
                    $display("FAIL %s beat%0d got d=%0d l=%b k=%h want d=%0d l=%b k=ff",
                             tag, got, tdata, tlast, tkeep, exp_beats[got], (got == NB - 1));
                end
                got++;
            end
            prev_stall = (tvalid === 1'b1) && !tready;
            prev = tdata;
            @(negedge clk);
            cyc++;
        end
        measure_in = 1'b0;
        checks++;
        if (got != NB) begin
            errors++;
            $display("FAIL %s timeout got %0d beats want %0d", tag, got, NB);
        end
        checks++;
        if (tvalid !== 1'b0 || tlast !== 1'b0) begin
            errors++;
            $display("FAIL %s after_last got v=%b l=%b want 0 0", tag, tvalid, tlast);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tvalid !== 1'b0 || tdata !== 64'd0 || tkeep !== 8'd0 || tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset got v=%b d=%0d k=%h l=%b want 0 0 0 0", tvalid, tdata, tkeep, tlast);
        end
        aresetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rising();
        samp_q = '{64'd64, 64'd128};
        drive_window(1'b0);
        collect(0, 1'b0, "rising");
    endtask

    task automatic test_falling();
        samp_q = '{64'd128, 64'd64};
        drive_window(1'b0);
        collect(0, 1'b0, "falling");
    endtask

    task automatic test_empty();
        samp_q.delete();
        drive_window(1'b0);
        collect(0, 1'b0, "empty");
    endtask

    task automatic test_backpressure();
        samp_q.delete();
        repeat (5) samp_q.push_back(64'($urandom_range(1, 9000)));
        drive_window(1'b0);
        collect(5, 1'b0, "backpressure");
    endtask

    task automatic test_boundary();
        samp_q.delete();
        repeat (4) samp_q.push_back(64'($urandom_range(1, 9000)));
        drive_window(1'b1);
        collect(6, 1'b1, "boundary");
    endtask

    task automatic test_reset_report();
        samp_q = '{64'd300, 64'd500, 64'd100};
        drive_window(1'b0);
        tready = 1'b1;
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b1 || tdata !== 64'd3) begin
            errors++;
            $display("FAIL rst_rpt beat1 got v=%b d=%0d want v=1 d=3", tvalid, tdata);
        end
        aresetn = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        checks++;
        if (tvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_rpt tvalid got %b want 0", tvalid);
        end
        samp_q = '{64'd40, 64'd72};
        drive_window(1'b0);
        collect(0, 1'b0, "rst_rpt_next");
    endtask

    task automatic test_random();
        for (int w = 0; w < 6; w++) begin
            samp_q.delete();
            repeat ($urandom_range(1, 12)) samp_q.push_back(64'($urandom_range(0, 1 << 20)));
            drive_window(bit'($urandom_range(0, 1)));
            collect($urandom_range(0, 3), 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_falling();
        test_empty();
        test_backpressure();
        test_boundary();
        test_reset_report();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
